cntr_load_arbiter: RTL and testbench

CNTR_LOAD_ARBITER -- requirements
Module: cntr_load_arbiter

---
 rtl/cntr_load_arbiter.sv | 101 ++++++++++
 tb/tb_cntr_load_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cntr_load_arbiter.sv
// Round-robin arbiter that lets two requesters share one saturating down
// counter: grants a requester, strobes its value into the counter, waits
// for the counter to reach zero and returns a one-cycle done pulse.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no operation; sample requests and grant one of them
//   LOAD   | cntr_load strobe high for this single cycle
//   SETTLE | counter is taking the new value; cntr_zeroed is not trusted
//   COUNT  | wait for cntr_zeroed
//   DONE   | done pulse to the owner; owner recorded for round-robin
module cntr_load_arbiter #(
   parameter int NUM_CNTR_BITS = 5
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     req_a,
   input  logic                     req_b,
   input  logic [NUM_CNTR_BITS-1:0] val_a,
   input  logic [NUM_CNTR_BITS-1:0] val_b,
   input  logic                     cntr_zeroed,
   output logic                     done_a,
   output logic                     done_b,
   output logic                     busy,
   output logic                     gnt_b,
   output logic                     cntr_load,
   output logic [NUM_CNTR_BITS-1:0] cntr_input
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      SETTLE = 3'd2,
      COUNT  = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   last_b;     // owner of the last completed operation (1 = B)
   logic   grant_b;

   // Round-robin pick: a lone request wins, a tie goes to whoever was not served last.
   always_comb begin
      grant_b = 1'b0;
      if (req_a && req_b) begin
         grant_b = ~last_b;
      end else begin
         grant_b = req_b;
      end
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_a || req_b) state_nxt = LOAD;
         LOAD:    state_nxt = SETTLE;
         SETTLE:  state_nxt = COUNT;
         COUNT:   if (cntr_zeroed) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Registered outputs, decoded from the next state so they line up with it.
   // last_b resets to B so that A wins the first tie after reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         busy       <= 1'b0;
         cntr_load  <= 1'b0;
         done_a     <= 1'b0;
         done_b     <= 1'b0;
         gnt_b      <= 1'b0;
         cntr_input <= '0;
         last_b     <= 1'b1;
      end else begin
         busy      <= (state_nxt != IDLE);
         cntr_load <= (state_nxt == LOAD);
         done_a    <= (state_nxt == DONE) && !gnt_b;
         done_b    <= (state_nxt == DONE) &&  gnt_b;
         if (state == IDLE && state_nxt == LOAD) begin
            gnt_b      <= grant_b;
            cntr_input <= grant_b ? val_b : val_a;
         end
         if (state == DONE) begin
            last_b <= gnt_b;
         end
      end
   end

endmodule

// File: tb/tb_cntr_load_arbiter.sv
// Bench for cntr_load_arbiter: a behavioural shared counter, a timeline
// model of the arbiter checked every cycle, and directed scenarios with
// hand-computed cycle numbers.
module tb_cntr_load_arbiter;
   localparam int W = 5;

   logic         clock   = 1'b0;
   logic         reset_n = 1'b0;
   logic         req_a   = 1'b0;
   logic         req_b   = 1'b0;
   logic [W-1:0] val_a   = '0;
   logic [W-1:0] val_b   = '0;
   logic         cntr_zeroed;
   logic         done_a, done_b, busy, gnt_b, cntr_load;
   logic [W-1:0] cntr_input;

   always #5 clock = ~clock;

   cntr_load_arbiter #(.NUM_CNTR_BITS(W)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .req_a       (req_a),
      .req_b       (req_b),
      .val_a       (val_a),
      .val_b       (val_b),
      .cntr_zeroed (cntr_zeroed),
      .done_a      (done_a),
      .done_b      (done_b),
      .busy        (busy),
      .gnt_b       (gnt_b),
      .cntr_load   (cntr_load),
      .cntr_input  (cntr_input)
   );

   // Shared saturating down counter, loads on a rising edge of cntr_load.
   logic [W-1:0] cnt       = '0;
   logic         prev_load = 1'b0;
   always @(posedge clock) begin
      if (cntr_load === 1'b1 && prev_load !== 1'b1) cnt <= cntr_input;
      else if (cnt != 0) cnt <= cnt - 1'b1;
      prev_load <= cntr_load;
   end
   assign cntr_zeroed = (cnt == 0);

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Timeline model: a grant in cycle g gives load at g+1, busy g+1..end,
   // done at end = g+3+max(V,1); the owner is remembered once done is reached.
   bit           m_active = 0;
   bit           m_gnt    = 0;
   bit           m_last_b = 1;
   logic [W-1:0] m_in     = '0;
   int           m_start  = 0;
   int           m_end    = 0;
   int           c_old;
   always @(posedge clock) begin
      c_old = cyc;
      cyc   = cyc + 1;
      if (!reset_n) begin
         m_active = 0;
         m_gnt    = 0;
         m_in     = '0;
         m_last_b = 1;
      end else if (m_active) begin
         if (c_old == m_end) begin
            m_active = 0;
            m_last_b = m_gnt;
         end
      end else if (req_a || req_b) begin
         m_gnt    = (req_a && req_b) ? !m_last_b : req_b;
         m_in     = m_gnt ? val_b : val_a;
         m_start  = c_old;
         m_end    = c_old + 3 + ((m_in == 0) ? 1 : int'(m_in));
         m_active = 1;
      end
   end

   // Per-cycle compare plus protocol invariants and event bookkeeping.
   int last_load = -100;
   int last_da   = -100;
   int last_db   = -100;
   int busy_cnt  = 0;
   bit gq[$];
   always @(negedge clock) begin
      if (cyc > 0) begin
         chk("busy",       busy,       m_active);
         chk("cntr_load",  cntr_load,  m_active && cyc == m_start + 1);
         chk("done_a",     done_a,     m_active && cyc == m_end && !m_gnt);
         chk("done_b",     done_b,     m_active && cyc == m_end &&  m_gnt);
         chk("gnt_b",      gnt_b,      m_gnt);
         chk("cntr_input", cntr_input, m_in);
         chk("one_done",   done_a & done_b, 0);
         if (cntr_load === 1'b1) begin
            chk("load_gap_ok", (cyc - last_load) >= 5, 1);
            last_load = cyc;
            gq.push_back(gnt_b);
         end
         if (done_a === 1'b1 || done_b === 1'b1) chk("cnt_zero_at_done", cnt, 0);
         if (done_a === 1'b1) last_da = cyc;
         if (done_b === 1'b1) last_db = cyc;
         if (busy === 1'b1) busy_cnt++;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   int t0, t1, b0;

   initial begin
      // Reset
      reset_n = 1'b0;
      step(3);
      chk("rst_busy",  busy,       0);
      chk("rst_load",  cntr_load,  0);
      chk("rst_gnt_b", gnt_b,      0);
      chk("rst_input", cntr_input, 0);
      chk("rst_done",  {done_a, done_b}, 0);

      // A alone, V=5, granted in the first cycle out of reset
      reset_n = 1'b1; req_a = 1'b1; val_a = 5'd5; t0 = cyc; b0 = busy_cnt;
      step(1); req_a = 1'b0;
      step(10);
      chk("t1_load_cycle", last_load - t0, 1);
      chk("t1_done_a",     last_da - t0,   8);
      chk("t1_busy_cnt",   busy_cnt - b0,  8);

      // B alone, V=0
      req_b = 1'b1; val_b = 5'd0; t0 = cyc;
      step(1); req_b = 1'b0;
      step(6);
      chk("t2_done_b", last_db - t0, 4);
      chk("t2_gnt_b",  gnt_b,        1);
      chk("t2_input",  cntr_input,   0);

      // Simultaneous A (3) and B (2), each dropped on its done
      req_a = 1'b1; req_b = 1'b1; val_a = 5'd3; val_b = 5'd2; t0 = cyc;
      for (int i = 0; i < 16; i++) begin
         step(1);
         if (done_a === 1'b1) req_a = 1'b0;
         if (done_b === 1'b1) req_b = 1'b0;
      end
      req_a = 1'b0; req_b = 1'b0;
      chk("t3_done_a",   last_da - t0,   6);
      chk("t3_load_b",   last_load - t0, 8);
      chk("t3_done_b",   last_db - t0,   12);

      // Both held for six operations: grants must alternate A,B,...
      gq.delete();
      val_a = 5'd2; val_b = 5'd1; req_a = 1'b1; req_b = 1'b1;
      for (int i = 0; i < 80 && gq.size() < 6; i++) step(1);
      req_a = 1'b0; req_b = 1'b0;
      step(8);
      chk("t4_ops", gq.size(), 6);
      for (int i = 0; i < gq.size() && i < 6; i++) chk("t4_grant_order", gq[i], i % 2);

      // Reset during COUNT aborts without done, then B completes normally
      req_a = 1'b1; val_a = 5'd31; t0 = cyc;
      step(1); req_a = 1'b0;
      step(9);
      reset_n = 1'b0;
      step(1);
      chk("t5_rst_outputs", {busy, cntr_load, gnt_b, done_a, done_b, cntr_input}, 0);
      step(1);
      reset_n = 1'b1; req_b = 1'b1; val_b = 5'd1; t1 = cyc;
      step(1); req_b = 1'b0;
      step(6);
      chk("t5_no_done_a", last_da < t0, 1);
      chk("t5_done_b",    last_db - t1, 4);

      // Maximum value
      req_a = 1'b1; val_a = 5'd31; t0 = cyc;
      step(1); req_a = 1'b0;
      step(36);
      chk("t6_done_a", last_da - t0, 34);
      chk("t6_input",  cntr_input,   31);
      chk("t6_cnt",    cnt,          0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
